// File: rtl/ecc_rd_pkg.sv
// Shared widths and the S2 payload layout for the ECC read stage.
package ecc_rd_pkg;
   localparam int DEF_DATA_WIDTH   = 78;
   localparam int DEF_PARITY_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH   = 10;
   localparam int DEF_CNT_WIDTH    = 16;

   typedef struct packed {
      logic [DEF_DATA_WIDTH-1:0]   data;
      logic                        sbit;
      logic                        dbit;
      logic [DEF_ADDR_WIDTH-1:0]   addr;
      logic [DEF_PARITY_WIDTH-1:0] syndrome;
   } s2_payload_t;
endpackage

// File: rtl/ecc_err_log.sv
// Saturating error counters, first-error capture record and double-error interrupt pulse.
module ecc_err_log #(
   parameter int ADDR_WIDTH   = 10,
   parameter int PARITY_WIDTH = 8,
   parameter int CNT_WIDTH    = 16
)(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    ev_i,
   input  logic                    sbit_i,
   input  logic                    dbit_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [PARITY_WIDTH-1:0] syn_i,
   input  logic                    clr_i,
   output logic [CNT_WIDTH-1:0]    sbit_cnt_o,
   output logic [CNT_WIDTH-1:0]    dbit_cnt_o,
   output logic                    cap_valid_o,
   output logic                    cap_dbit_o,
   output logic [ADDR_WIDTH-1:0]   cap_addr_o,
   output logic [PARITY_WIDTH-1:0] cap_syn_o,
   output logic                    irq_o
);
   logic [CNT_WIDTH-1:0]    scnt_q, scnt_d, dcnt_q, dcnt_d;
   logic                    cap_valid_q, cap_valid_d, cap_dbit_q, cap_dbit_d;
   logic [ADDR_WIDTH-1:0]   cap_addr_q, cap_addr_d;
   logic [PARITY_WIDTH-1:0] cap_syn_q, cap_syn_d;
   logic                    irq_q, irq_d;

   // Clear is applied first so a same-cycle event lands on the cleared state.
   always_comb begin
      scnt_d      = clr_i ? '0 : scnt_q;
      dcnt_d      = clr_i ? '0 : dcnt_q;
      cap_valid_d = clr_i ? 1'b0 : cap_valid_q;
      cap_dbit_d  = clr_i ? 1'b0 : cap_dbit_q;
      cap_addr_d  = clr_i ? '0 : cap_addr_q;
      cap_syn_d   = clr_i ? '0 : cap_syn_q;
      irq_d       = ev_i && dbit_i;
      if (ev_i && sbit_i && scnt_d != '1) scnt_d = scnt_d + CNT_WIDTH'(1);
      if (ev_i && dbit_i && dcnt_d != '1) dcnt_d = dcnt_d + CNT_WIDTH'(1);
      if (ev_i && (sbit_i || dbit_i) && (!cap_valid_d || (dbit_i && !cap_dbit_d))) begin
         cap_valid_d = 1'b1;
         cap_dbit_d  = dbit_i;
         cap_addr_d  = addr_i;
         cap_syn_d   = syn_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scnt_q      <= '0;
         dcnt_q      <= '0;
         cap_valid_q <= 1'b0;
         cap_dbit_q  <= 1'b0;
         cap_addr_q  <= '0;
         cap_syn_q   <= '0;
         irq_q       <= 1'b0;
      end else begin
         scnt_q      <= scnt_d;
         dcnt_q      <= dcnt_d;
         cap_valid_q <= cap_valid_d;
         cap_dbit_q  <= cap_dbit_d;
         cap_addr_q  <= cap_addr_d;
         cap_syn_q   <= cap_syn_d;
         irq_q       <= irq_d;
      end
   end

   assign sbit_cnt_o  = scnt_q;
   assign dbit_cnt_o  = dcnt_q;
   assign cap_valid_o = cap_valid_q;
   assign cap_dbit_o  = cap_dbit_q;
   assign cap_addr_o  = cap_addr_q;
   assign cap_syn_o   = cap_syn_q;
   assign irq_o       = irq_q;
endmodule

// File: rtl/secded_78_8_dec.sv
// Combinational 78/8 Hsiao SECDED decoder: recomputes parity, corrects one bit, flags uncorrectable words.
module secded_78_8_dec (
   input  logic [77:0] data_i,
   input  logic [7:0]  parity_i,
   output logic [77:0] data_o,
   output logic [7:0]  parity_o,
   output logic        sbit_o,
   output logic        dbit_o
);
   // Data columns: all weight-3 bytes then weight-5 bytes, ascending, rotated right by one.
   function automatic logic [623:0] gen_cols();
      logic [623:0] c;
      logic [7:0]   v;
      int           n;
      int           w1;
      c = '0;
      n = 0;
      for (int w = 3; w <= 5; w += 2) begin
         for (int k = 0; k < 256; k++) begin
            v  = 8'(k);
            w1 = 0;
            for (int b = 0; b < 8; b++) w1 += int'(v[b]);
            if (w1 == w && n < 78) begin
               c[n*8 +: 8] = {v[0], v[7:1]};
               n++;
            end
         end
      end
      return c;
   endfunction

   localparam logic [623:0] H_COLS = gen_cols();

   logic [7:0] syn;
   logic       hit;

   always_comb begin
      parity_o = '0;
      for (int i = 0; i < 78; i++) begin
         if (data_i[i]) parity_o = parity_o ^ H_COLS[i*8 +: 8];
      end
   end

   assign syn = parity_o ^ parity_i;

   always_comb begin
      data_o = data_i;
      hit    = $onehot(syn);
      for (int i = 0; i < 78; i++) begin
         if (syn == H_COLS[i*8 +: 8]) begin
            data_o[i] = ~data_i[i];
            hit       = 1'b1;
         end
      end
   end

   assign sbit_o = hit;
   assign dbit_o = (syn != 8'h00) && !hit;
endmodule

// File: rtl/ecc_rd_stage.sv
// Two-register valid/ready read stage: S1 holds the stored word, S2 holds the corrected result.
module ecc_rd_stage
   import ecc_rd_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int PARITY_WIDTH = DEF_PARITY_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int CNT_WIDTH    = DEF_CNT_WIDTH
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [PARITY_WIDTH-1:0] in_parity,
   input  logic [ADDR_WIDTH-1:0]   in_addr,
   input  logic                    bypass,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    out_sbit,
   output logic                    out_dbit,
   input  logic                    cnt_clr,
   output logic [CNT_WIDTH-1:0]    sbit_cnt,
   output logic [CNT_WIDTH-1:0]    dbit_cnt,
   output logic                    cap_valid,
   output logic                    cap_dbit,
   output logic [ADDR_WIDTH-1:0]   cap_addr,
   output logic [PARITY_WIDTH-1:0] cap_syndrome,
   output logic                    dbit_irq
);
   logic                    s1_valid_q, s2_valid_q;
   logic [DATA_WIDTH-1:0]   s1_data_q;
   logic [PARITY_WIDTH-1:0] s1_parity_q;
   logic [ADDR_WIDTH-1:0]   s1_addr_q;
   s2_payload_t             s2_q, s2_d;
   logic                    s2_ready, decode_ev;
   logic [DATA_WIDTH-1:0]   dec_data;
   logic [PARITY_WIDTH-1:0] dec_parity;
   logic                    dec_sbit, dec_dbit;

   assign s2_ready  = !s2_valid_q || out_ready;
   assign in_ready  = !s1_valid_q || s2_ready;
   assign decode_ev = s1_valid_q && s2_ready;

   secded_78_8_dec u_dec (
      .data_i   (s1_data_q),
      .parity_i (s1_parity_q),
      .data_o   (dec_data),
      .parity_o (dec_parity),
      .sbit_o   (dec_sbit),
      .dbit_o   (dec_dbit)
   );

   always_comb begin
      s2_d          = '0;
      s2_d.data     = bypass ? s1_data_q : dec_data;
      s2_d.sbit     = !bypass && dec_sbit;
      s2_d.dbit     = !bypass && dec_dbit;
      s2_d.addr     = s1_addr_q;
      s2_d.syndrome = dec_parity ^ s1_parity_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_parity_q <= '0;
         s1_addr_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_q        <= '0;
      end else begin
         if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_data_q   <= in_data;
               s1_parity_q <= in_parity;
               s1_addr_q   <= in_addr;
            end
         end
         if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) s2_q <= s2_d;
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_q.data;
   assign out_sbit  = s2_q.sbit;
   assign out_dbit  = s2_q.dbit;

   ecc_err_log #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .PARITY_WIDTH (PARITY_WIDTH),
      .CNT_WIDTH    (CNT_WIDTH)
   ) u_err_log (
      .clk_i       (clk),
      .rst_i       (rst),
      .ev_i        (decode_ev),
      .sbit_i      (s2_d.sbit),
      .dbit_i      (s2_d.dbit),
      .addr_i      (s1_addr_q),
      .syn_i       (s2_d.syndrome),
      .clr_i       (cnt_clr),
      .sbit_cnt_o  (sbit_cnt),
      .dbit_cnt_o  (dbit_cnt),
      .cap_valid_o (cap_valid),
      .cap_dbit_o  (cap_dbit),
      .cap_addr_o  (cap_addr),
      .cap_syn_o   (cap_syndrome),
      .irq_o       (dbit_irq)
   );
endmodule

// File: tb/tb_ecc_rd_stage.sv
// Self-checking bench for ecc_rd_stage against a brute-force SECDED reference model.
module tb_ecc_rd_stage;
   typedef struct packed {
      logic [77:0] d;
      logic        s;
      logic        b;
   } wrd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [77:0] in_data = '0;
   logic [7:0]  in_parity = '0;
   logic [9:0]  in_addr = '0;
   logic        bypass = 1'b0;
   logic        out_valid, out_ready = 1'b1;
   logic [77:0] out_data;
   logic        out_sbit, out_dbit;
   logic        cnt_clr = 1'b0;
   logic [15:0] sbit_cnt, dbit_cnt;
   logic        cap_valid, cap_dbit;
   logic [9:0]  cap_addr;
   logic [7:0]  cap_syndrome;
   logic        dbit_irq;

   int asserts = 0;
   int fails = 0;

   logic [7:0] hcol [86];
   wrd_t       exp_q[$];
   wrd_t       obs_q[$];
   int         m_scnt, m_dcnt, m_irq, irq_seen;
   logic       m_cap_valid, m_cap_dbit;
   logic [9:0] m_cap_addr;
   logic [7:0] m_cap_syn;

   always #5 clk = ~clk;

   ecc_rd_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_parity(in_parity), .in_addr(in_addr), .bypass(bypass),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sbit(out_sbit), .out_dbit(out_dbit), .cnt_clr(cnt_clr),
      .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .cap_valid(cap_valid),
      .cap_dbit(cap_dbit), .cap_addr(cap_addr), .cap_syndrome(cap_syndrome),
      .dbit_irq(dbit_irq)
   );

   always @(negedge clk) begin
      if (out_valid && out_ready) obs_q.push_back({out_data, out_sbit, out_dbit});
      if (dbit_irq) irq_seen++;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Hsiao code: weight-3 then weight-5 bytes, rotated right by one; parity bit j is 1<<j.
   function automatic void build_h();
      int n = 0;
      for (int w = 3; w <= 5; w += 2)
         for (int k = 0; k < 256; k++)
            if ($countones(8'(k)) == w && n < 78) begin
               hcol[n] = 8'(((k >> 1) | (k << 7)) & 255);
               n++;
            end
      for (int j = 0; j < 8; j++) hcol[78+j] = 8'(1 << j);
   endfunction

   function automatic logic [7:0] enc(input logic [77:0] d);
      logic [7:0] p = '0;
      for (int i = 0; i < 78; i++) if (d[i]) p ^= hcol[i];
      return p;
   endfunction

   function automatic void ref_decode(input logic [77:0] d, input logic [7:0] p,
                                      output logic [77:0] cd, output logic sb,
                                      output logic db, output logic [7:0] syn);
      int pos = -1;
      syn = enc(d) ^ p;
      cd  = d;
      sb  = 1'b0;
      db  = 1'b0;
      if (syn != 8'h00) begin
         for (int i = 0; i < 86; i++) if (hcol[i] == syn) pos = i;
         if (pos >= 0) begin
            sb = 1'b1;
            if (pos < 78) cd[pos] = ~cd[pos];
         end else db = 1'b1;
      end
   endfunction

   function automatic void model_clear();
      m_scnt = 0; m_dcnt = 0;
      m_cap_valid = 1'b0; m_cap_dbit = 1'b0; m_cap_addr = '0; m_cap_syn = '0;
   endfunction

   function automatic void model_accept(input logic [77:0] d, input logic [7:0] p, input logic [9:0] a);
      logic [77:0] cd;
      logic        sb, db;
      logic [7:0]  syn;
      ref_decode(d, p, cd, sb, db, syn);
      if (bypass) begin cd = d; sb = 1'b0; db = 1'b0; end
      exp_q.push_back({cd, sb, db});
      if (sb && m_scnt < 65535) m_scnt++;
      if (db && m_dcnt < 65535) m_dcnt++;
      if (db) m_irq++;
      if ((sb || db) && (!m_cap_valid || (db && !m_cap_dbit))) begin
         m_cap_valid = 1'b1; m_cap_dbit = db; m_cap_addr = a; m_cap_syn = syn;
      end
   endfunction

   task automatic rand_word(input int nerr, output logic [77:0] d, output logic [7:0] p);
      logic [95:0] r;
      logic [85:0] cw;
      int i, j;
      r  = {$urandom(), $urandom(), $urandom()};
      cw = {enc(r[77:0]), r[77:0]};
      i  = $urandom_range(0, 85);
      if (nerr >= 1) cw[i] = ~cw[i];
      if (nerr == 2) begin
         j = $urandom_range(0, 85);
         while (j == i) j = $urandom_range(0, 85);
         cw[j] = ~cw[j];
      end
      d = cw[77:0];
      p = cw[85:78];
   endtask

   // Called at #1 after a rising edge; returns at #1 after the accepting edge.
   task automatic push(input logic [77:0] d, input logic [7:0] p, input logic [9:0] a);
      int n = 0;
      in_valid = 1'b1; in_data = d; in_parity = p; in_addr = a;
      @(negedge clk);
      while (!in_ready && n < 200) begin n++; @(negedge clk); end
      asserts++;
      if (!in_ready) begin
         fails++;
         $display("FAIL push_accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
      end else model_accept(d, p, a);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((out_valid || obs_q.size() != exp_q.size()) && n < 500) begin
         @(posedge clk); #2; n++;
      end
      asserts++;
      if (out_valid || obs_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL drain: out=%0d words, required %0d", obs_q.size(), exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      asserts++;
      if ({out_valid, out_data, out_sbit, out_dbit, dbit_irq} !== '0) begin
         fails++; $display("FAIL reset_out: valid=%b data=%h sbit=%b dbit=%b irq=%b, required all 0",
                           out_valid, out_data, out_sbit, out_dbit, dbit_irq);
      end
      asserts++;
      if ({sbit_cnt, dbit_cnt, cap_valid, cap_dbit, cap_addr, cap_syndrome} !== '0) begin
         fails++; $display("FAIL reset_log: scnt=%h dcnt=%h cap=%b/%b/%h/%h, required all 0",
                           sbit_cnt, dbit_cnt, cap_valid, cap_dbit, cap_addr, cap_syndrome);
      end
      asserts++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
   endtask

   task automatic test_clean();
      in_valid = 1'b1; in_data = '0; in_parity = '0; in_addr = 10'h005;
      @(negedge clk);
      asserts++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL clean_accept: in_ready=%b, required 1", in_ready); end
      model_accept('0, '0, 10'h005);
      @(posedge clk); #1;
      in_valid = 1'b0;
      asserts++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL clean_lat1: out_valid=%b, required 0", out_valid); end
      @(posedge clk); #1;
      asserts++;
      if ({out_valid, out_data, out_sbit, out_dbit} !== {1'b1, 78'h0, 2'b00}) begin
         fails++; $display("FAIL clean_lat2: valid=%b data=%h sbit=%b dbit=%b, required 1/0/0/0",
                           out_valid, out_data, out_sbit, out_dbit);
      end
      wait_drain();
      asserts++;
      if ({sbit_cnt, dbit_cnt, cap_valid} !== '0) begin
         fails++; $display("FAIL clean_cnt: scnt=%0d dcnt=%0d cap=%b, required 0", sbit_cnt, dbit_cnt, cap_valid);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_single();
      push(78'h1, 8'h00, 10'h155);
      wait_drain();
      asserts++;
      if (obs_q[$] !== {78'h0, 1'b1, 1'b0}) begin
         fails++; $display("FAIL single_out: data=%h s=%b d=%b, required 0/1/0", obs_q[$].d, obs_q[$].s, obs_q[$].b);
      end
      asserts++;
      if ({sbit_cnt, cap_valid, cap_dbit, cap_addr, cap_syndrome} !== {16'd1, 1'b1, 1'b0, 10'h155, 8'h83}) begin
         fails++; $display("FAIL single_log: scnt=%0d cap=%b/%b addr=%h syn=%h, required 1 1/0 155 83",
                           sbit_cnt, cap_valid, cap_dbit, cap_addr, cap_syndrome);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_parity_only();
      push(78'h0, 8'h01, 10'h2AA);
      wait_drain();
      asserts++;
      if (obs_q[$] !== {78'h0, 1'b1, 1'b0}) begin
         fails++; $display("FAIL parity_out: data=%h s=%b d=%b, required 0/1/0", obs_q[$].d, obs_q[$].s, obs_q[$].b);
      end
      asserts++;
      if ({sbit_cnt, cap_addr} !== {16'd2, 10'h155}) begin
         fails++; $display("FAIL parity_log: scnt=%0d cap_addr=%h, required 2 155", sbit_cnt, cap_addr);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_double();
      irq_seen = 0;
      push(78'h3, 8'h00, 10'h0F0);
      wait_drain();
      asserts++;
      if ({obs_q[$].s, obs_q[$].b} !== 2'b01) begin
         fails++; $display("FAIL double_out: s=%b d=%b, required 0/1", obs_q[$].s, obs_q[$].b);
      end
      asserts++;
      if ({dbit_cnt, sbit_cnt} !== {16'd1, 16'd2} || irq_seen != 1) begin
         fails++; $display("FAIL double_cnt: dcnt=%0d scnt=%0d irq_cycles=%0d, required 1 2 1", dbit_cnt, sbit_cnt, irq_seen);
      end
      asserts++;
      if ({cap_valid, cap_dbit, cap_addr} !== {1'b1, 1'b1, 10'h0F0}) begin
         fails++; $display("FAIL double_cap: cap=%b/%b addr=%h, required 1/1 0F0", cap_valid, cap_dbit, cap_addr);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_bypass();
      logic [77:0] d;
      logic [7:0]  p;
      int          irq0 = irq_seen;
      bypass = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rand_word(k % 3, d, p);
         push(d, p, 10'(k));
      end
      wait_drain();
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         asserts++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++; $display("FAIL bypass_word%0d: data=%h s=%b d=%b, required %h %b %b",
                              i, obs_q[i].d, obs_q[i].s, obs_q[i].b, exp_q[i].d, exp_q[i].s, exp_q[i].b);
         end
      end
      asserts++;
      if (sbit_cnt !== 16'd2 || dbit_cnt !== 16'd1 || irq_seen != irq0) begin
         fails++; $display("FAIL bypass_cnt: scnt=%0d dcnt=%0d irq=%0d, required 2 1 %0d", sbit_cnt, dbit_cnt, irq_seen, irq0);
      end
      bypass = 1'b0;
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_backpressure();
      logic [77:0] d, hold;
      logic [7:0]  p;
      int          acc = 0;
      logic        took;
      out_ready = 1'b0;
      rand_word(1, d, p);
      in_valid = 1'b1; in_data = d; in_parity = p; in_addr = 10'h100;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         took = in_ready;
         if (took) begin model_accept(in_data, in_parity, in_addr); acc++; end
         @(posedge clk); #1;
         if (took) begin
            rand_word(acc % 3, d, p);
            in_data = d; in_parity = p; in_addr = 10'(10'h100 + acc);
         end
      end
      hold = out_data;
      asserts++;
      if (acc != 2 || in_ready !== 1'b0) begin
         fails++; $display("FAIL bp_full: accepted=%0d in_ready=%b, required 2 0", acc, in_ready);
      end
      @(posedge clk); #1;
      asserts++;
      if (out_valid !== 1'b1 || out_data !== hold) begin
         fails++; $display("FAIL bp_hold: valid=%b data=%h, required 1 %h", out_valid, out_data, hold);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         asserts++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++; $display("FAIL bp_word%0d: data=%h s=%b d=%b, required %h %b %b",
                              i, obs_q[i].d, obs_q[i].s, obs_q[i].b, exp_q[i].d, exp_q[i].s, exp_q[i].b);
         end
      end
      asserts++;
      if (sbit_cnt !== 16'(m_scnt) || dbit_cnt !== 16'(m_dcnt)) begin
         fails++; $display("FAIL bp_cnt: scnt=%0d dcnt=%0d, required %0d %0d", sbit_cnt, dbit_cnt, m_scnt, m_dcnt);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_random();
      logic [77:0] d;
      logic [7:0]  p;
      bit          done = 1'b0;
      irq_seen = 0; m_irq = 0;
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               rand_word(($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 2), d, p);
               push(d, p, 10'($urandom_range(0, 1023)));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      wait_drain();
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         asserts++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++; $display("FAIL rand_word%0d: data=%h s=%b d=%b, required %h %b %b",
                              i, obs_q[i].d, obs_q[i].s, obs_q[i].b, exp_q[i].d, exp_q[i].s, exp_q[i].b);
         end
      end
      asserts++;
      if (sbit_cnt !== 16'(m_scnt) || dbit_cnt !== 16'(m_dcnt) || irq_seen != m_irq) begin
         fails++; $display("FAIL rand_cnt: scnt=%0d dcnt=%0d irq=%0d, required %0d %0d %0d",
                           sbit_cnt, dbit_cnt, irq_seen, m_scnt, m_dcnt, m_irq);
      end
      asserts++;
      if ({cap_valid, cap_dbit, cap_addr, cap_syndrome} !== {m_cap_valid, m_cap_dbit, m_cap_addr, m_cap_syn}) begin
         fails++; $display("FAIL rand_cap: %b/%b/%h/%h, required %b/%b/%h/%h", cap_valid, cap_dbit, cap_addr,
                           cap_syndrome, m_cap_valid, m_cap_dbit, m_cap_addr, m_cap_syn);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_saturation();
      logic [77:0] d;
      logic [7:0]  p;
      int          bad = 0;
      while (m_scnt < 65535) begin
         rand_word(1, d, p);
         push(d, p, 10'h3FF);
      end
      wait_drain();
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad++;
      asserts++;
      if (bad != 0) begin fails++; $display("FAIL sat_words: %0d wrong words, required 0", bad); end
      asserts++;
      if (sbit_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_reach: scnt=%h, required FFFF", sbit_cnt); end
      rand_word(1, d, p);
      push(d, p, 10'h3FF);
      wait_drain();
      asserts++;
      if (sbit_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: scnt=%h, required FFFF", sbit_cnt); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_clear();
      model_clear();
      push(78'h1, 8'h00, 10'h3C3);
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      wait_drain();
      asserts++;
      if ({sbit_cnt, dbit_cnt} !== {16'd1, 16'd0}) begin
         fails++; $display("FAIL clr_cnt: scnt=%0d dcnt=%0d, required 1 0", sbit_cnt, dbit_cnt);
      end
      asserts++;
      if ({cap_valid, cap_dbit, cap_addr, cap_syndrome} !== {1'b1, 1'b0, 10'h3C3, 8'h83}) begin
         fails++; $display("FAIL clr_cap: %b/%b/%h/%h, required 1/0/3C3/83", cap_valid, cap_dbit, cap_addr, cap_syndrome);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [77:0] d;
      logic [7:0]  p;
      out_ready = 1'b0;
      rand_word(1, d, p); push(d, p, 10'h011);
      rand_word(2, d, p); push(d, p, 10'h022);
      asserts++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_full: in_ready=%b, required 0", in_ready); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete(); obs_q.delete(); model_clear();
      out_ready = 1'b1;
      asserts++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || {sbit_cnt, dbit_cnt, cap_valid} !== '0) begin
         fails++; $display("FAIL mid_rst: valid=%b in_ready=%b scnt=%0d dcnt=%0d cap=%b, required 0 1 0 0 0",
                           out_valid, in_ready, sbit_cnt, dbit_cnt, cap_valid);
      end
      repeat (4) @(posedge clk);
      #1;
      asserts++;
      if (obs_q.size() != 0) begin fails++; $display("FAIL mid_discard: %0d words emerged, required 0", obs_q.size()); end
      rand_word(0, d, p);
      push(d, p, 10'h033);
      wait_drain();
      asserts++;
      if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
         fails++; $display("FAIL mid_resume: %0d words, data=%h, required 1 word %h", obs_q.size(),
                           (obs_q.size() > 0) ? obs_q[0].d : 78'h0, exp_q[0].d);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      build_h();
      model_clear();
      m_irq = 0; irq_seen = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_clean();
      test_single();
      test_parity_only();
      test_double();
      test_bypass();
      test_backpressure();
      test_random();
      test_saturation();
      test_clear();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
